id_stage_pipe: RTL

//  Registered RV32I decode stage sitting between IF_ID and EX. Classifies all base opcodes, generates

---
 rtl/id_stage_pipe_pkg.sv | 73 +++++++
 rtl/id_stage_pipe_imm_gen.sv | 36 +++
 rtl/id_stage_pipe.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_pipe_pkg.sv
// Shared RV32I decode constants: opcodes, ALU op codes, result classes, control bundle.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package id_stage_pipe_pkg;

    // Base opcodes (inst[6:0])
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // ALU operation codes
    localparam logic [7:0] EXE_NOP_OP  = 8'h00;
    localparam logic [7:0] EXE_ADD_OP  = 8'h01;
    localparam logic [7:0] EXE_SUB_OP  = 8'h02;
    localparam logic [7:0] EXE_SLL_OP  = 8'h03;
    localparam logic [7:0] EXE_SLT_OP  = 8'h04;
    localparam logic [7:0] EXE_SLTU_OP = 8'h05;
    localparam logic [7:0] EXE_XOR_OP  = 8'h06;
    localparam logic [7:0] EXE_SRL_OP  = 8'h07;
    localparam logic [7:0] EXE_SRA_OP  = 8'h08;
    localparam logic [7:0] EXE_OR_OP   = 8'h09;
    localparam logic [7:0] EXE_AND_OP  = 8'h0A;
    localparam logic [7:0] EXE_LUI_OP  = 8'h0B;
    localparam logic [7:0] EXE_JAL_OP  = 8'h0D;
    localparam logic [7:0] EXE_JALR_OP = 8'h0E;
    localparam logic [7:0] EXE_BEQ_OP  = 8'h10;
    localparam logic [7:0] EXE_BNE_OP  = 8'h11;
    localparam logic [7:0] EXE_BLT_OP  = 8'h12;
    localparam logic [7:0] EXE_BGE_OP  = 8'h13;
    localparam logic [7:0] EXE_BLTU_OP = 8'h14;
    localparam logic [7:0] EXE_BGEU_OP = 8'h15;
    localparam logic [7:0] EXE_LB_OP   = 8'h18;
    localparam logic [7:0] EXE_LH_OP   = 8'h19;
    localparam logic [7:0] EXE_LW_OP   = 8'h1A;
    localparam logic [7:0] EXE_LBU_OP  = 8'h1B;
    localparam logic [7:0] EXE_LHU_OP  = 8'h1C;
    localparam logic [7:0] EXE_SB_OP   = 8'h20;
    localparam logic [7:0] EXE_SH_OP   = 8'h21;
    localparam logic [7:0] EXE_SW_OP   = 8'h22;

    // Result classes
    localparam logic [2:0] EXE_RES_NOP    = 3'd0;
    localparam logic [2:0] EXE_RES_LOGIC  = 3'd1;
    localparam logic [2:0] EXE_RES_SHIFT  = 3'd2;
    localparam logic [2:0] EXE_RES_ARITH  = 3'd3;
    localparam logic [2:0] EXE_RES_JUMP   = 3'd4;
    localparam logic [2:0] EXE_RES_BRANCH = 3'd5;
    localparam logic [2:0] EXE_RES_LOAD   = 3'd6;
    localparam logic [2:0] EXE_RES_STORE  = 3'd7;

    // Decoded control bundle; operand-select bits steer reg1/reg2 muxing.
    typedef struct packed {
        logic [7:0] aluop;
        logic [2:0] alusel;
        logic       wreg;
        logic       illegal;
        logic       use_rs1;
        logic       use_rs2;
        logic       op1_pc;
        logic       op2_imm;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{aluop: EXE_NOP_OP, alusel: EXE_RES_NOP, default: '0};

endpackage

// File: rtl/id_stage_pipe_imm_gen.sv
// Immediate generator: picks the I/S/B/U/J immediate by opcode, sign-extended to XLEN.
// Latency: combinational.
// Backpressure: none; pure function of the instruction word.
module id_stage_pipe_imm_gen
    import id_stage_pipe_pkg::*;
#(
    parameter int XLEN = 32
)(
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    // Format select by opcode; opcodes without an immediate yield zero
    always_comb begin
        imm32 = 32'd0;
        case (inst[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR:
                imm32 = {{20{inst[31]}}, inst[31:20]};
            OPC_STORE:
                imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OPC_BRANCH:
                imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm32 = {inst[31:12], 12'd0};
            OPC_JAL:
                imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:
                imm32 = 32'd0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/id_stage_pipe.sv
// RV32I decode stage: classify, build immediates, forward operands, register into ID/EX.
// Latency: one cycle from accept (id_ready_o && if_valid_i) to ex_valid_o.
// Backpressure: ID/EX holds while ex_ready_i=0 and valid; load-use inserts one bubble; flush_i squashes.
module id_stage_pipe
    import id_stage_pipe_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int RADDR_W    = 5,
    parameter int FWD_SRCS   = 2,
    parameter bit ILLEGAL_EN = 1'b1
)(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    input  logic                         if_valid_i,
    output logic                         id_ready_o,
    input  logic [XLEN-1:0]              pc_i,
    input  logic [31:0]                  inst_i,
    output logic                         reg1_read_o,
    output logic                         reg2_read_o,
    output logic [RADDR_W-1:0]           reg1_addr_o,
    output logic [RADDR_W-1:0]           reg2_addr_o,
    input  logic [XLEN-1:0]              reg1_data_i,
    input  logic [XLEN-1:0]              reg2_data_i,
    input  logic [FWD_SRCS-1:0]          fwd_wen_i,
    input  logic [FWD_SRCS*RADDR_W-1:0]  fwd_waddr_i,
    input  logic [FWD_SRCS*XLEN-1:0]     fwd_wdata_i,
    input  logic                         ex_load_i,
    input  logic [RADDR_W-1:0]           ex_rd_i,
    input  logic                         ex_ready_i,
    output logic                         ex_valid_o,
    output logic [7:0]                   aluop_o,
    output logic [2:0]                   alusel_o,
    output logic [XLEN-1:0]              reg1_o,
    output logic [XLEN-1:0]              reg2_o,
    output logic [XLEN-1:0]              imm_o,
    output logic [RADDR_W-1:0]           rd_o,
    output logic                         wreg_o,
    output logic [XLEN-1:0]              pc_o,
    output logic                         illegal_o
);

    typedef struct packed {
        logic               valid;
        logic [7:0]         aluop;
        logic [2:0]         alusel;
        logic [XLEN-1:0]    reg1;
        logic [XLEN-1:0]    reg2;
        logic [XLEN-1:0]    imm;
        logic [RADDR_W-1:0] rd;
        logic               wreg;
        logic [XLEN-1:0]    pc;
        logic               illegal;
    } idex_t;

    localparam idex_t IDEX_BUBBLE = '{aluop: EXE_NOP_OP, alusel: EXE_RES_NOP, default: '0};

    ctrl_t              ctrl;
    logic               bad;
    logic [XLEN-1:0]    imm;
    logic [RADDR_W-1:0] rs1, rs2, rd;
    logic [XLEN-1:0]    rs1_val, rs2_val;
    logic               hazard, adv;
    idex_t              idex_d, idex_q;

    assign rs1 = RADDR_W'(inst_i[19:15]);
    assign rs2 = RADDR_W'(inst_i[24:20]);
    assign rd  = RADDR_W'(inst_i[11:7]);

    id_stage_pipe_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst (inst_i),
        .imm  (imm)
    );

    // Opcode/funct decode into ALU op, result class and operand steering
    always_comb begin
        ctrl = CTRL_NOP;
        bad  = 1'b0;
        case (inst_i[6:0])
            OPC_LUI: begin
                ctrl.aluop = EXE_LUI_OP; ctrl.alusel = EXE_RES_ARITH;
                ctrl.wreg = 1'b1; ctrl.op2_imm = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl.aluop = EXE_ADD_OP; ctrl.alusel = EXE_RES_ARITH;
                ctrl.wreg = 1'b1; ctrl.op1_pc = 1'b1; ctrl.op2_imm = 1'b1;
            end
            OPC_JAL: begin
                ctrl.aluop = EXE_JAL_OP; ctrl.alusel = EXE_RES_JUMP;
                ctrl.wreg = 1'b1; ctrl.op1_pc = 1'b1; ctrl.op2_imm = 1'b1;
            end
            OPC_JALR: begin
                ctrl.aluop = EXE_JALR_OP; ctrl.alusel = EXE_RES_JUMP;
                ctrl.wreg = 1'b1; ctrl.use_rs1 = 1'b1; ctrl.op2_imm = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl.alusel = EXE_RES_BRANCH; ctrl.use_rs1 = 1'b1; ctrl.use_rs2 = 1'b1;
                case (inst_i[14:12])
                    3'b000:  ctrl.aluop = EXE_BEQ_OP;
                    3'b001:  ctrl.aluop = EXE_BNE_OP;
                    3'b100:  ctrl.aluop = EXE_BLT_OP;
                    3'b101:  ctrl.aluop = EXE_BGE_OP;
                    3'b110:  ctrl.aluop = EXE_BLTU_OP;
                    3'b111:  ctrl.aluop = EXE_BGEU_OP;
                    default: bad = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                ctrl.alusel = EXE_RES_LOAD; ctrl.wreg = 1'b1;
                ctrl.use_rs1 = 1'b1; ctrl.op2_imm = 1'b1;
                case (inst_i[14:12])
                    3'b000:  ctrl.aluop = EXE_LB_OP;
                    3'b001:  ctrl.aluop = EXE_LH_OP;
                    3'b010:  ctrl.aluop = EXE_LW_OP;
                    3'b100:  ctrl.aluop = EXE_LBU_OP;
                    3'b101:  ctrl.aluop = EXE_LHU_OP;
                    default: bad = 1'b1;
                endcase
            end
            OPC_STORE: begin
                ctrl.alusel = EXE_RES_STORE; ctrl.use_rs1 = 1'b1; ctrl.use_rs2 = 1'b1;
                case (inst_i[14:12])
                    3'b000:  ctrl.aluop = EXE_SB_OP;
                    3'b001:  ctrl.aluop = EXE_SH_OP;
                    3'b010:  ctrl.aluop = EXE_SW_OP;
                    default: bad = 1'b1;
                endcase
            end
            OPC_OP_IMM, OPC_OP: begin
                ctrl.wreg    = 1'b1;
                ctrl.use_rs1 = 1'b1;
                ctrl.use_rs2 = (inst_i[6:0] == OPC_OP);
                ctrl.op2_imm = (inst_i[6:0] == OPC_OP_IMM);
                ctrl.alusel  = EXE_RES_ARITH;
                case (inst_i[14:12])
                    3'b000: ctrl.aluop = (ctrl.use_rs2 && inst_i[30]) ? EXE_SUB_OP : EXE_ADD_OP;
                    3'b010: ctrl.aluop = EXE_SLT_OP;
                    3'b011: ctrl.aluop = EXE_SLTU_OP;
                    3'b100: begin ctrl.aluop = EXE_XOR_OP; ctrl.alusel = EXE_RES_LOGIC; end
                    3'b110: begin ctrl.aluop = EXE_OR_OP;  ctrl.alusel = EXE_RES_LOGIC; end
                    3'b111: begin ctrl.aluop = EXE_AND_OP; ctrl.alusel = EXE_RES_LOGIC; end
                    3'b001: begin ctrl.aluop = EXE_SLL_OP; ctrl.alusel = EXE_RES_SHIFT; end
                    default: begin
                        ctrl.aluop  = inst_i[30] ? EXE_SRA_OP : EXE_SRL_OP;
                        ctrl.alusel = EXE_RES_SHIFT;
                    end
                endcase
            end
            OPC_MISC_MEM, OPC_SYSTEM: ctrl = CTRL_NOP;
            default: bad = 1'b1;
        endcase
        // Anything unrecognised travels down the pipe as a NOP, optionally flagged
        if (bad) begin
            ctrl         = CTRL_NOP;
            ctrl.illegal = ILLEGAL_EN;
        end
    end

    assign reg1_read_o = ctrl.use_rs1;
    assign reg2_read_o = ctrl.use_rs2;
    assign reg1_addr_o = rs1;
    assign reg2_addr_o = rs2;

    // Operand fetch: regfile value overridden by forwarding, index 0 applied last so it wins
    always_comb begin
        rs1_val = reg1_data_i;
        rs2_val = reg2_data_i;
        for (int k = FWD_SRCS - 1; k >= 0; k--) begin
            if (fwd_wen_i[k] && fwd_waddr_i[k*RADDR_W +: RADDR_W] == rs1)
                rs1_val = fwd_wdata_i[k*XLEN +: XLEN];
            if (fwd_wen_i[k] && fwd_waddr_i[k*RADDR_W +: RADDR_W] == rs2)
                rs2_val = fwd_wdata_i[k*XLEN +: XLEN];
        end
        if (rs1 == '0) rs1_val = '0;
        if (rs2 == '0) rs2_val = '0;
    end

    assign hazard = if_valid_i && ex_load_i && (ex_rd_i != '0) &&
                    ((ctrl.use_rs1 && ex_rd_i == rs1) || (ctrl.use_rs2 && ex_rd_i == rs2));
    assign adv        = ex_ready_i || !idex_q.valid;
    assign id_ready_o = adv && !hazard && !flush_i;

    // Next ID/EX contents: decoded op when accepted, otherwise a bubble
    always_comb begin
        idex_d = IDEX_BUBBLE;
        if (if_valid_i && !hazard && !flush_i) begin
            idex_d.valid   = 1'b1;
            idex_d.aluop   = ctrl.aluop;
            idex_d.alusel  = ctrl.alusel;
            idex_d.reg1    = ctrl.op1_pc  ? pc_i : (ctrl.use_rs1 ? rs1_val : '0);
            idex_d.reg2    = ctrl.op2_imm ? imm  : (ctrl.use_rs2 ? rs2_val : '0);
            idex_d.imm     = imm;
            idex_d.rd      = rd;
            idex_d.wreg    = ctrl.wreg && (rd != '0);
            idex_d.pc      = pc_i;
            idex_d.illegal = ctrl.illegal;
        end
    end

    // ID/EX register: loads on advance, flush forces a bubble even while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idex_q <= IDEX_BUBBLE;
        else if (flush_i || adv)
            idex_q <= idex_d;
    end

    assign ex_valid_o = idex_q.valid;
    assign aluop_o    = idex_q.aluop;
    assign alusel_o   = idex_q.alusel;
    assign reg1_o     = idex_q.reg1;
    assign reg2_o     = idex_q.reg2;
    assign imm_o      = idex_q.imm;
    assign rd_o       = idex_q.rd;
    assign wreg_o     = idex_q.wreg;
    assign pc_o       = idex_q.pc;
    assign illegal_o  = idex_q.illegal;

endmodule
